fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 16'h0000: PC value loaded on reset; bit 0 is ignored and treated as 0.
REQ-002 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-003 Port rst  input  1: reset, synchronous and active-low (rst=0 resets on the clock edge).
REQ-004 Port imem_addr  output  16: fetch address to instruction memory read_address; equals the current PC.
REQ-005 Port imem_data  input  16: instruction word returned combinationally, in the same cycle, for imem_addr.
REQ-006 Port redirect_valid  input  1: branch/jump redirect request from a later stage.
REQ-007 Port redirect_pc  input  16: redirect target; bit 0 is forced to 0.
REQ-008 Port id_valid  output  1: buffer head holds a valid instruction for decode.
REQ-009 Port id_ready  input  1: decode accepts the head entry this cycle.
REQ-010 Port id_instr  output  16: head-entry instruction.
REQ-011 Port id_pc  output  16: head-entry PC.

Function
REQ-012 The block SHALL hold a 16-bit PC and a 2-entry FIFO of {pc, instr} with a 2-bit occupancy count (0..2).
REQ-013 pop = id_valid & id_ready; id_valid = (count != 0); when count == 0, id_instr and id_pc SHALL be 16'h0000.
REQ-014 push = ~redirect_valid & ((count < 2) | pop); push writes {PC, imem_data} and sets PC <= PC + 2.
REQ-015 PC arithmetic SHALL be modulo 2^16, so 16'hFFFE + 2 wraps to 16'h0000 with no error indication.
REQ-016 With push and pop in the same cycle, count is unchanged and FIFO order is preserved; with count == 2 and no pop, PC holds and no push occurs (stall).
REQ-017 redirect_valid=1 has priority over push and pop: FIFO flushes (count <= 0), PC <= {redirect_pc[15:1],1'b0}, no push, and any concurrent pop is discarded.
REQ-018 Redirect latency: redirect in cycle N makes imem_addr = target in N+1, and id_valid=1 with id_pc = target in N+2 unless a further redirect occurs.
REQ-019 Fetch latency: an instruction pushed in cycle N SHALL be visible at the head no earlier than cycle N+1; there is no combinational path from imem_data to id_instr.
REQ-020 id_valid, id_instr and id_pc SHALL stay stable while id_valid=1 and id_ready=0, unless a redirect occurs.
REQ-021 Back-to-back redirects SHALL each take effect; the last one wins.

Reset
REQ-022 On a clock edge with rst=0: PC <= RESET_PC with bit 0 cleared, count <= 0, FIFO contents <= 0, and the performance counter (when built) <= 0.
REQ-023 During reset and in the first cycle after it, id_valid=0, id_instr=0, id_pc=0, and imem_addr = RESET_PC.
REQ-024 Reset asserted mid-operation SHALL discard all buffered entries and any pending redirect in that cycle; reset has priority over redirect.
REQ-025 The first push SHALL occur in the first cycle with rst=1, and id_valid SHALL rise one cycle later.

Configuration
REQ-026 With macro FETCH_PERF_CNT_EN defined, output fetch_cnt (16 bits) SHALL exist; it increments on every pop, saturates at 16'hFFFF and is cleared by reset.
REQ-027 Without FETCH_PERF_CNT_EN, port fetch_cnt and its logic SHALL be absent, and all other behaviour is identical.

Verification
REQ-028 Reset release, memory returning 16'h0001 at 0x0 and 16'h0D91 at 0x2, id_ready=1 -> id_pc/id_instr = 0x0000/0x0001, then 0x0002/0x0D91, one per cycle.
REQ-029 id_ready=0 for 5 cycles -> count reaches 2, imem_addr freezes at 0x0004, head stays 0x0000/0x0001; releasing id_ready drains the entries in order 0x0000, then 0x0002.
REQ-030 redirect_valid=1 with redirect_pc=16'h0031 while the FIFO is full -> next cycle count=0 and imem_addr=0x0030; one cycle later id_pc=0x0030.
REQ-031 RESET_PC=16'hFFFC, id_ready=1 -> id_pc sequence 0xFFFC, 0xFFFE, 0x0000, 0x0002.
REQ-032 rst=0 asserted for one cycle with 2 entries buffered -> following cycle id_valid=0, imem_addr=RESET_PC, and fetch_cnt=0 when FETCH_PERF_CNT_EN is defined.
REQ-033 FETCH_PERF_CNT_EN defined, 70000 pops -> fetch_cnt holds 16'hFFFF.

Source files
------------

// File: rtl/fetch_if.sv
// fetch_if: fetch unit bus to instruction memory, redirect source and decode stage
interface fetch_if;
  logic [15:0] imem_addr, imem_data, redirect_pc, id_instr, id_pc;
  logic redirect_valid, id_valid, id_ready;
  modport master(output imem_addr, id_valid, id_instr, id_pc,
                 input imem_data, redirect_valid, redirect_pc, id_ready);
  modport slave(input imem_addr, id_valid, id_instr, id_pc,
                output imem_data, redirect_valid, redirect_pc, id_ready);
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: PC generator feeding a 2-entry {pc,instr} buffer; FETCH_PERF_CNT_EN adds fetch_cnt pop counter
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input logic clk,
  input logic rst,
  fetch_if.master bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0] fetch_cnt
`endif
);
  localparam logic [15:0] RST_PC = {RESET_PC[15:1], 1'b0};
  logic [15:0] pc_q, pc_d, pc0_q, pc0_d, in0_q, in0_d, pc1_q, pc1_d, in1_q, in1_d;
  logic [1:0] cnt_q, cnt_d, cnt_mid;
  logic pop, push, wr0, wr1;
  assign bus.imem_addr = pc_q;
  assign bus.id_valid = cnt_q != 2'd0;
  assign bus.id_pc = bus.id_valid ? pc0_q : 16'h0000;
  assign bus.id_instr = bus.id_valid ? in0_q : 16'h0000;
  assign pop = bus.id_valid & bus.id_ready;
  assign push = ~bus.redirect_valid & ((cnt_q != 2'd2) | pop);
  // Entry 0 is the head; a pop shifts entry 1 down before the new word lands in the first free slot
  always_comb begin
    cnt_mid = cnt_q - {1'b0, pop};
    wr0 = push & (cnt_mid == 2'd0);
    wr1 = push & (cnt_mid == 2'd1);
    pc0_d = wr0 ? pc_q : pop ? pc1_q : pc0_q;
    in0_d = wr0 ? bus.imem_data : pop ? in1_q : in0_q;
    pc1_d = wr1 ? pc_q : pc1_q;
    in1_d = wr1 ? bus.imem_data : in1_q;
    cnt_d = bus.redirect_valid ? 2'd0 : cnt_mid + {1'b0, push};
    pc_d = bus.redirect_valid ? {bus.redirect_pc[15:1], 1'b0} : push ? pc_q + 16'd2 : pc_q;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q <= RST_PC;
      cnt_q <= 2'd0;
      pc0_q <= 16'h0000;
      in0_q <= 16'h0000;
      pc1_q <= 16'h0000;
      in1_q <= 16'h0000;
    end else begin
      pc_q <= pc_d;
      cnt_q <= cnt_d;
      pc0_q <= pc0_d;
      in0_q <= in0_d;
      pc1_q <= pc1_d;
      in1_q <= in1_d;
    end
  end
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_cnt_q, fetch_cnt_d;
  // Pops discarded by a redirect are not counted as delivered instructions
  always_comb fetch_cnt_d = (pop & ~bus.redirect_valid & (fetch_cnt_q != 16'hFFFF)) ? fetch_cnt_q + 16'd1 : fetch_cnt_q;
  always_ff @(posedge clk) begin
    if (!rst) fetch_cnt_q <= 16'h0000;
    else fetch_cnt_q <= fetch_cnt_d;
  end
  assign fetch_cnt = fetch_cnt_q;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and random checks of fetch_unit against a queue-based reference model
module tb_fetch_unit;
  logic clk = 1'b0, rst = 1'b0, rst2 = 1'b0;
  always #5 clk = ~clk;
  fetch_if bus();
  fetch_if bus2();
  logic [15:0] mem [0:32767];
  assign bus.imem_data = mem[bus.imem_addr[15:1]];
  assign bus2.imem_data = mem[bus2.imem_addr[15:1]];
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fc, fc2;
  fetch_unit dut(.clk(clk), .rst(rst), .bus(bus), .fetch_cnt(fc));
  fetch_unit #(.RESET_PC(16'hFFFC)) dut2(.clk(clk), .rst(rst2), .bus(bus2), .fetch_cnt(fc2));
`else
  fetch_unit dut(.clk(clk), .rst(rst), .bus(bus));
  fetch_unit #(.RESET_PC(16'hFFFC)) dut2(.clk(clk), .rst(rst2), .bus(bus2));
`endif
  int checks = 0, errors = 0;
  logic [15:0] pc_m = 16'h0000, cnt_m = 16'h0000;
  logic [31:0] q_m[$];
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic r, input logic rv, input logic [15:0] rp, input logic rdy);
    rst = r;
    bus.redirect_valid = rv;
    bus.redirect_pc = rp;
    bus.id_ready = rdy;
    if (!r) begin
      q_m.delete();
      pc_m = 16'h0000;
      cnt_m = 16'h0000;
    end else if (rv) begin
      q_m.delete();
      pc_m = {rp[15:1], 1'b0};
    end else begin
      if (rdy && q_m.size() > 0) begin
        void'(q_m.pop_front());
        if (cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'd1;
      end
      if (q_m.size() < 2) begin
        q_m.push_back({pc_m, mem[pc_m[15:1]]});
        pc_m = pc_m + 16'd2;
      end
    end
    @(posedge clk);
    #1;
    chk("imem_addr", bus.imem_addr, pc_m);
    chk("id_valid", {15'd0, bus.id_valid}, {15'd0, q_m.size() != 0});
    chk("id_pc", bus.id_pc, q_m.size() != 0 ? q_m[0][31:16] : 16'h0000);
    chk("id_instr", bus.id_instr, q_m.size() != 0 ? q_m[0][15:0] : 16'h0000);
`ifdef FETCH_PERF_CNT_EN
    chk("fetch_cnt", fc, cnt_m);
`endif
  endtask
  initial begin
    logic [15:0] exp2 [4];
    exp2 = '{16'hFFFC, 16'hFFFE, 16'h0000, 16'h0002};
    for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h0001;
    mem[1] = 16'h0D91;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 16'h0000;
    bus.id_ready = 1'b0;
    bus2.redirect_valid = 1'b0;
    bus2.redirect_pc = 16'h0000;
    bus2.id_ready = 1'b1;
    step(1'b0, 1'b0, 16'h0, 1'b1);
    step(1'b0, 1'b1, 16'h1234, 1'b1);
    chk("rst_valid", {15'd0, bus.id_valid}, 16'd0);
    chk("rst_addr", bus.imem_addr, 16'h0000);
    step(1'b1, 1'b0, 16'h0, 1'b1);
    chk("seq_pc0", bus.id_pc, 16'h0000);
    chk("seq_in0", bus.id_instr, 16'h0001);
    step(1'b1, 1'b0, 16'h0, 1'b1);
    chk("seq_pc1", bus.id_pc, 16'h0002);
    chk("seq_in1", bus.id_instr, 16'h0D91);
    step(1'b0, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 16'h0, 1'b0);
    chk("stall_addr", bus.imem_addr, 16'h0004);
    chk("stall_pc", bus.id_pc, 16'h0000);
    chk("stall_in", bus.id_instr, 16'h0001);
    step(1'b1, 1'b0, 16'h0, 1'b1);
    chk("drain_pc", bus.id_pc, 16'h0002);
    step(1'b1, 1'b0, 16'h0, 1'b0);
    step(1'b1, 1'b0, 16'h0, 1'b0);
    step(1'b1, 1'b1, 16'h0031, 1'b0);
    chk("redir_valid", {15'd0, bus.id_valid}, 16'd0);
    chk("redir_addr", bus.imem_addr, 16'h0030);
    step(1'b1, 1'b0, 16'h0, 1'b0);
    chk("redir_pc", bus.id_pc, 16'h0030);
    step(1'b1, 1'b0, 16'h0, 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b0);
    chk("mid_rst_valid", {15'd0, bus.id_valid}, 16'd0);
    chk("mid_rst_addr", bus.imem_addr, 16'h0000);
    step(1'b1, 1'b1, 16'h1234, 1'b1);
    step(1'b1, 1'b1, 16'hFFFD, 1'b1);
    chk("b2b_addr", bus.imem_addr, 16'hFFFC);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 16'h0, 1'b1);
    for (int i = 0; i < 500; i++)
      step(($urandom % 40) != 0, ($urandom % 8) == 0, 16'($urandom), 1'($urandom));
    chk("dut2_rst_addr", bus2.imem_addr, 16'hFFFC);
    chk("dut2_rst_valid", {15'd0, bus2.id_valid}, 16'd0);
    rst2 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("dut2_pc", bus2.id_pc, exp2[i]);
      chk("dut2_in", bus2.id_instr, mem[exp2[i][15:1]]);
    end
`ifdef FETCH_PERF_CNT_EN
    step(1'b0, 1'b0, 16'h0, 1'b1);
    for (int i = 0; i < 70001; i++) step(1'b1, 1'b0, 16'h0, 1'b1);
    chk("cnt_sat", fc, 16'hFFFF);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
